// File: rtl/red_pitaya_dacbuf_wr.sv
// DAC buffer writer: streams 64-bit sample words into ping-pong
// half-buffers of a selected DAC channel, gated by half-free flags.
module red_pitaya_dacbuf_wr #(
  parameter int AW = 12,
  parameter int CW = 16
) (
  input  logic          dacbuf_clk_i,
  input  logic          dacbuf_rstn_i,
  input  logic          cfg_en_i,
  input  logic          cfg_ch_i,
  input  logic [CW-1:0] cfg_halves_i,
  input  logic [63:0]   s_tdata_i,
  input  logic          s_tvalid_i,
  output logic          s_tready_o,
  input  logic [1:0]    dacbuf_ready_a_i,
  input  logic [1:0]    dacbuf_ready_b_i,
  output logic [1:0]    dacbuf_select_o,
  output logic [AW-1:0] dacbuf_waddr_o,
  output logic [63:0]   dacbuf_wdata_o,
  output logic          dacbuf_valid_o,
  output logic          sts_busy_o,
  output logic          sts_done_o,
  output logic [CW-1:0] sts_halves_o
);

  localparam int NW = AW - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FILL,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            ch_q, ch_d;
  logic [CW-1:0]   lim_q, lim_d;
  logic            h_q, h_d;
  logic [NW-1:0]   n_q, n_d;
  logic [CW-1:0]   halves_q, halves_d;
  logic            valid_q, valid_d;
  logic [1:0]      sel_q, sel_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [63:0]     wdata_q, wdata_d;

  logic [1:0]      rdy;
  logic            beat;
  logic            last;
  logic [CW-1:0]   halves_inc;

  assign rdy        = ch_q ? dacbuf_ready_b_i : dacbuf_ready_a_i;
  assign beat       = (state_q == S_FILL) & s_tvalid_i;
  assign last       = &n_q;
  assign halves_inc = halves_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    lim_d    = lim_q;
    h_d      = h_q;
    n_d      = n_q;
    halves_d = halves_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_en_i) begin
          state_d  = S_WAIT;
          ch_d     = cfg_ch_i;
          lim_d    = cfg_halves_i;
          h_d      = 1'b0;
          n_d      = '0;
          halves_d = '0;
        end
      end
      S_WAIT: begin
        if (!cfg_en_i)
          state_d = S_IDLE;
        else if (rdy[h_q])
          state_d = S_FILL;
      end
      S_FILL: begin
        if (beat) begin
          n_d = n_q + NW'(1);
          if (last) begin
            h_d      = ~h_q;
            halves_d = halves_inc;
          end
        end
        // abort wins, but the beat of this cycle is still written
        if (!cfg_en_i)
          state_d = S_IDLE;
        else if (beat && last)
          state_d = ((lim_q != '0) && (halves_inc == lim_q))
                    ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        if (!cfg_en_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = beat;
    sel_d   = 2'b00;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (beat) begin
      sel_d   = ch_q ? 2'b10 : 2'b01;
      waddr_d = {h_q, n_q};
      wdata_d = s_tdata_i;
    end
  end

  always_ff @(posedge dacbuf_clk_i or negedge dacbuf_rstn_i) begin
    if (!dacbuf_rstn_i) begin
      state_q  <= S_IDLE;
      ch_q     <= 1'b0;
      lim_q    <= '0;
      h_q      <= 1'b0;
      n_q      <= '0;
      halves_q <= '0;
      valid_q  <= 1'b0;
      sel_q    <= 2'b00;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      lim_q    <= lim_d;
      h_q      <= h_d;
      n_q      <= n_d;
      halves_q <= halves_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign s_tready_o      = (state_q == S_FILL);
  assign dacbuf_valid_o  = valid_q;
  assign dacbuf_select_o = sel_q;
  assign dacbuf_waddr_o  = waddr_q;
  assign dacbuf_wdata_o  = wdata_q;
  assign sts_busy_o      = (state_q != S_IDLE);
  assign sts_done_o      = (state_q == S_DONE);
  assign sts_halves_o    = halves_q;

endmodule

// File: tb/tb_red_pitaya_dacbuf_wr.sv
// Directed bench for the DAC buffer writer: fills, ping-pong,
// ready gating, stream stalls, abort and asynchronous reset.
module tb_red_pitaya_dacbuf_wr;

  localparam int AW = 12;
  localparam int CW = 16;
  localparam int HW = 2048;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          ch = 1'b0;
  logic [CW-1:0] halves = '0;
  logic [63:0]   tdata = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [1:0]    rdya = 2'b00;
  logic [1:0]    rdyb = 2'b00;
  logic [1:0]    sel;
  logic [AW-1:0] waddr;
  logic [63:0]   wdata;
  logic          wvalid;
  logic          busy;
  logic          done;
  logic [CW-1:0] shalves;

  red_pitaya_dacbuf_wr #(.AW(AW), .CW(CW)) dut (
    .dacbuf_clk_i     (clk),
    .dacbuf_rstn_i    (rstn),
    .cfg_en_i         (en),
    .cfg_ch_i         (ch),
    .cfg_halves_i     (halves),
    .s_tdata_i        (tdata),
    .s_tvalid_i       (tvalid),
    .s_tready_o       (tready),
    .dacbuf_ready_a_i (rdya),
    .dacbuf_ready_b_i (rdyb),
    .dacbuf_select_o  (sel),
    .dacbuf_waddr_o   (waddr),
    .dacbuf_wdata_o   (wdata),
    .dacbuf_valid_o   (wvalid),
    .sts_busy_o       (busy),
    .sts_done_o       (done),
    .sts_halves_o     (shalves)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int dcount = 0;

  logic          w_v, w_done, acc;
  logic [AW-1:0] w_a;
  logic [63:0]   w_d;
  logic [1:0]    w_s;

  function automatic logic [63:0] dat(int k);
    return {16'hBEEF, 16'h0000, 32'(k)};
  endfunction

  // one clock: sample outputs at negedge, advance data after accepted beat
  task automatic cyc();
    @(negedge clk);
    w_v    = wvalid;
    w_a    = waddr;
    w_d    = wdata;
    w_s    = sel;
    w_done = done;
    acc    = tvalid & tready;
    @(posedge clk);
    #1;
    if (acc) dcount++;
    tdata = dat(dcount);
  endtask

  task automatic start(input logic c, input logic [CW-1:0] h,
                       input logic [1:0] ra, input logic [1:0] rb);
    dcount = 0;
    tdata  = dat(0);
    ch     = c;
    halves = h;
    rdya   = ra;
    rdyb   = rb;
    tvalid = 1'b1;
    en     = 1'b1;
  endtask

  task automatic stop();
    en     = 1'b0;
    tvalid = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({tready, wvalid, sel} !== 4'b0) begin
      errs++;
      $display("FAIL reset_strobe got=%b exp=0000",
               {tready, wvalid, sel});
    end
    checks++;
    if ({waddr, wdata} !== '0) begin
      errs++;
      $display("FAIL reset_bus got=%h/%h exp=0/0", waddr, wdata);
    end
    checks++;
    if ({busy, done, shalves} !== '0) begin
      errs++;
      $display("FAIL reset_sts got=%b/%b/%0d exp=0/0/0",
               busy, done, shalves);
    end
    rstn = 1'b1;
    cyc();
    cyc();
    checks++;
    if (busy !== 1'b0 || w_v !== 1'b0) begin
      errs++;
      $display("FAIL idle_after_reset got=%b/%b exp=0/0", busy, w_v);
    end
  endtask

  task automatic run_fill(input string nm, input logic [1:0] xs,
                          input int nexp, input int hexp);
    int  nwr, bad, extra;
    logic fin;
    nwr = 0; bad = 0; extra = 0; fin = 1'b0;
    for (int i = 0; i < nexp + 1000 && !fin; i++) begin
      cyc();
      if (w_v) begin
        if (w_a !== AW'(nwr) || w_d !== dat(nwr) || w_s !== xs) begin
          if (bad == 0)
            $display("FAIL %s_wr#%0d got=%h/%h/%b exp=%h/%h/%b",
                     nm, nwr, w_a, w_d, w_s, AW'(nwr), dat(nwr), xs);
          bad++;
        end
        nwr++;
      end
      if (w_done) fin = 1'b1;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL %s_seq got=%0d bad exp=0", nm, bad);
    end
    checks++;
    if (fin !== 1'b1 || nwr != nexp) begin
      errs++;
      $display("FAIL %s_count got=%0d done=%b exp=%0d done=1",
               nm, nwr, fin, nexp);
    end
    checks++;
    if (shalves !== CW'(hexp) || tready !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL %s_sts got=%0d/%b/%b exp=%0d/0/1",
               nm, shalves, tready, busy, hexp);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (w_v) extra++;
    end
    checks++;
    if (extra != 0 || done !== 1'b1) begin
      errs++;
      $display("FAIL %s_hold got=%0d writes done=%b exp=0 done=1",
               nm, extra, done);
    end
    stop();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL %s_idle got=%b/%b exp=0/0", nm, busy, done);
    end
  endtask

  task automatic test_single();
    start(1'b0, CW'(1), 2'b01, 2'b00);
    run_fill("single", 2'b01, HW, 1);
  endtask

  task automatic test_pingpong();
    start(1'b1, CW'(3), 2'b00, 2'b11);
    run_fill("pingpong", 2'b10, 3 * HW, 3);
  endtask

  task automatic test_gating();
    int nwr, ntr, lat, bad;
    nwr = 0; ntr = 0; lat = 0; bad = 0;
    // channel B flags are set but must not release channel A
    start(1'b0, CW'(0), 2'b00, 2'b11);
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (w_v) nwr++;
      if (acc) ntr++;
    end
    checks++;
    if (nwr != 0 || ntr != 0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL gate_wait got=%0d wr %0d rdy busy=%b exp=0 0 1",
               nwr, ntr, busy);
    end
    rdya = 2'b01;
    for (int i = 0; i < 10 && lat == 0; i++) begin
      cyc();
      if (w_v) lat = i + 1;
    end
    // write lands on the 2nd edge after the flag, seen on 3rd sample
    checks++;
    if (lat == 0 || lat > 3 || w_a !== '0) begin
      errs++;
      $display("FAIL gate_start got=lat%0d addr%0d exp=lat<=3 addr0",
               lat, w_a);
    end
    nwr = 1;
    for (int i = 0; i < HW + 100 && nwr < HW; i++) begin
      cyc();
      if (w_v) begin
        if (w_a !== AW'(nwr)) bad++;
        nwr++;
      end
    end
    checks++;
    if (nwr != HW || bad != 0) begin
      errs++;
      $display("FAIL gate_half got=%0d wr %0d bad exp=%0d 0",
               nwr, bad, HW);
    end
    nwr = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (w_v) nwr++;
    end
    checks++;
    if (nwr != 0 || tready !== 1'b0 || shalves !== CW'(1)
        || busy !== 1'b1) begin
      errs++;
      $display("FAIL gate_stall got=%0d wr rdy=%b h=%0d exp=0 0 1",
               nwr, tready, shalves);
    end
    stop();
  endtask

  task automatic test_stall();
    int  nwr, badl, bads;
    logic prev;
    nwr = 0; badl = 0; bads = 0; prev = 1'b0;
    start(1'b0, CW'(1), 2'b01, 2'b00);
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (w_v !== prev) badl++;
      if (w_v) begin
        if (w_a !== AW'(nwr) || w_d !== dat(nwr)) bads++;
        nwr++;
      end
      prev = acc;
      tvalid = ~tvalid;
    end
    checks++;
    if (badl != 0) begin
      errs++;
      $display("FAIL stall_latency got=%0d bad exp=0", badl);
    end
    checks++;
    if (bads != 0 || nwr < 20 || nwr > 30) begin
      errs++;
      $display("FAIL stall_seq got=%0d bad %0d wr exp=0 20..30",
               bads, nwr);
    end
    stop();
  endtask

  task automatic test_abort();
    int nwr, bad, la;
    nwr = 0; bad = 0; la = -1;
    start(1'b0, CW'(0), 2'b11, 2'b00);
    for (int i = 0; i < 1000 && dcount < 500; i++) begin
      cyc();
      if (w_v) begin
        if (w_a !== AW'(nwr)) bad++;
        nwr++;
      end
    end
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (w_v) begin
        if (w_a !== AW'(nwr)) bad++;
        la = int'(w_a);
        nwr++;
      end
    end
    checks++;
    if (nwr != 501 || la != 500 || bad != 0) begin
      errs++;
      $display("FAIL abort_trail got=%0d wr last=%0d exp=501 last=500",
               nwr, la);
    end
    checks++;
    if (busy !== 1'b0 || tready !== 1'b0) begin
      errs++;
      $display("FAIL abort_idle got=%b/%b exp=0/0", busy, tready);
    end
    start(1'b0, CW'(0), 2'b11, 2'b00);
    cyc();
    checks++;
    if (shalves !== '0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL abort_reen got=%0d/%b exp=0/1", shalves, busy);
    end
    la = -1;
    for (int i = 0; i < 10 && la < 0; i++) begin
      cyc();
      if (w_v) la = int'(w_a);
    end
    checks++;
    if (la != 0 || w_d !== dat(0)) begin
      errs++;
      $display("FAIL abort_restart got=%0d/%h exp=0/%h",
               la, w_d, dat(0));
    end
    stop();
  endtask

  task automatic test_async_reset();
    int nwr, la;
    nwr = 0; la = -1;
    start(1'b0, CW'(0), 2'b01, 2'b00);
    for (int i = 0; i < 1200 && dcount < 1000; i++) cyc();
    checks++;
    if (wvalid !== 1'b1 || tready !== 1'b1 || waddr !== AW'(999)) begin
      errs++;
      $display("FAIL arst_pre got=%b/%b/%0d exp=1/1/999",
               wvalid, tready, waddr);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({wvalid, sel, tready} !== 4'b0) begin
      errs++;
      $display("FAIL arst_strobe got=%b exp=0000",
               {wvalid, sel, tready});
    end
    checks++;
    if ({waddr, wdata, busy, done, shalves} !== '0) begin
      errs++;
      $display("FAIL arst_regs got=%h/%h/%b/%b/%0d exp=0",
               waddr, wdata, busy, done, shalves);
    end
    en = 1'b0;
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (w_v) nwr++;
    end
    checks++;
    if (nwr != 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL arst_release got=%0d wr busy=%b exp=0 0",
               nwr, busy);
    end
    start(1'b0, CW'(0), 2'b01, 2'b00);
    for (int i = 0; i < 10 && la < 0; i++) begin
      cyc();
      if (w_v) la = int'(w_a);
    end
    checks++;
    if (la != 0 || shalves !== '0) begin
      errs++;
      $display("FAIL arst_restart got=%0d/%0d exp=0/0", la, shalves);
    end
    stop();
  endtask

  initial begin
    test_reset();
    test_single();
    test_pingpong();
    test_gating();
    test_stall();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
